// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline sequencing controller.
// Holds the FSM encoding, the zero-register id and the canned control bundles.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_hold;
    logic exmem_flush;
  } ctrl_t;

  // Free-running pipe: every buffer loads, nothing is cleared.
  localparam ctrl_t CTRL_RUN = '{
    pc_write:    1'b1,
    pc_src:      1'b0,
    ifid_write:  1'b1,
    ifid_flush:  1'b0,
    idex_write:  1'b1,
    idex_flush:  1'b0,
    exmem_hold:  1'b0,
    exmem_flush: 1'b0
  };

  // Whole pipe waits on data memory; EX/MEM keeps the outstanding access.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_write:    1'b0,
    pc_src:      1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b0,
    idex_write:  1'b0,
    idex_flush:  1'b0,
    exmem_hold:  1'b1,
    exmem_flush: 1'b0
  };

  // Redirect fetch and squash the three younger wrong-path instructions.
  localparam ctrl_t CTRL_BRANCH = '{
    pc_src:      1'b1,
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b1,
    idex_write:  1'b1,
    idex_flush:  1'b1,
    exmem_hold:  1'b0,
    exmem_flush: 1'b1
  };

  // Hold PC and IF/ID for one cycle and push a bubble into ID/EX.
  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_write:    1'b0,
    pc_src:      1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b0,
    idex_write:  1'b1,
    idex_flush:  1'b1,
    exmem_hold:  1'b0,
    exmem_flush: 1'b0
  };

  function automatic logic load_use_hit(
    input logic       memread,
    input logic [4:0] dst,
    input logic [4:0] src_a,
    input logic [4:0] src_b
  );
    return memread && (dst != REG_ZERO) && ((dst == src_a) || (dst == src_b));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait/timeout handling, plus stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             exmem_flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  ctrl_t      ctrl;

  logic load_use;
  logic branch_taken;
  logic frozen;

  assign load_use     = load_use_hit(ex_memread, ex_rt, id_rs, id_rt);
  assign branch_taken = mem_branch && mem_zero;

  // Freeze covers the wait-entry cycle too, so the stalled access never slips.
  assign frozen = (state_q == ST_FAULT) ||
                  ((state_q == ST_MEM_WAIT) && !dmem_ready) ||
                  ((state_q == ST_RUN) && mem_access && !dmem_ready);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_access && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (!reset) begin
      ctrl = CTRL_RUN;
    end else if (frozen) begin
      ctrl = CTRL_FREEZE;
    end else if (branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_write  = ctrl.idex_write;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_hold  = ctrl.exmem_hold;
  assign exmem_flush = ctrl.exmem_flush;
  assign mem_fault   = fault_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!ctrl.pc_write),
    .count(stall_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (ctrl.pc_src),
    .count(flush_count)
  );

endmodule
